// File: rtl/mux_pipe_skid_pkg.sv
// Shared constants, select-width helper and default payload layout for the
// registered N:1 selector family.
package mux_pipe_skid_pkg;

  localparam int DATA_W    = 32;
  localparam int MAX_N     = 16;
  localparam int MAX_SEL_W = 4;

  // Ceiling log2, used to size the select field from the channel count.
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // {sel, data} pair for the default 32-bit, up-to-16-channel configuration.
  typedef struct packed {
    logic [MAX_SEL_W-1:0] sel;
    logic [DATA_W-1:0]    data;
  } payload_t;

endpackage

// File: rtl/mux_pipe_skid_nsel.sv
// Purely combinational N:1 selector; out-of-range selects return DEFAULT_VAL.
module mux_nsel
  import mux_pipe_skid_pkg::*;
#(
  parameter int          WIDTH       = DATA_W,
  parameter int          N           = 2,
  parameter logic [31:0] DEFAULT_VAL = 32'h0,
  localparam int         SEL_W       = clog2(N)
) (
  input  logic [N*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]   sel_i,
  output logic [WIDTH-1:0]   data_o
);

  // Size cast truncates or zero-extends the 32-bit default to WIDTH.
  localparam logic [WIDTH-1:0] DEF_W = WIDTH'(DEFAULT_VAL);

  always_comb begin
    data_o = DEF_W;
    for (int k = 0; k < N; k++) begin
      if (sel_i == SEL_W'(k)) begin
        data_o = data_i[k*WIDTH +: WIDTH];
      end
    end
  end

endmodule

// File: rtl/mux_pipe_skid.sv
// N:1 selector with a registered output (M), a one-entry skid register (S)
// and valid/ready handshakes on both sides; entries leave strictly M before S.
module mux_pipe_skid
  import mux_pipe_skid_pkg::*;
#(
  parameter int          WIDTH       = DATA_W,
  parameter int          N           = 2,
  parameter logic [31:0] DEFAULT_VAL = 32'h0,
  localparam int         SEL_W       = clog2(N)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]   in_sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready
);

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
  } ent_t;

  ent_t             m_q, m_d;
  ent_t             s_q, s_d;
  logic             m_vld_q, m_vld_d;
  logic             s_vld_q, s_vld_d;
  logic [WIDTH-1:0] sel_val;
  ent_t             in_ent;
  logic             accept;
  logic             emit;

  mux_nsel #(
    .WIDTH       (WIDTH),
    .N           (N),
    .DEFAULT_VAL (DEFAULT_VAL)
  ) u_nsel (
    .data_i (in_data),
    .sel_i  (in_sel),
    .data_o (sel_val)
  );

  assign in_ent = {in_sel, sel_val};

  // Ready depends only on skid occupancy, never on out_ready.
  assign in_ready  = !s_vld_q && !rst;
  assign accept    = in_valid && in_ready;
  assign emit      = m_vld_q && out_ready;

  assign out_valid = m_vld_q;
  assign out_data  = m_q.data;
  assign out_sel   = m_q.sel;

  always_comb begin
    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    if (flush) begin
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (!m_vld_q || emit) begin
      // M is free this cycle: the skid entry is older than any new input.
      if (s_vld_q) begin
        m_d     = s_q;
        m_vld_d = 1'b1;
        s_vld_d = 1'b0;
      end else if (accept) begin
        m_d     = in_ent;
        m_vld_d = 1'b1;
      end else begin
        m_vld_d = 1'b0;
      end
    end else if (accept) begin
      s_d     = in_ent;
      s_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
      m_q     <= '0;
    end else begin
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
      m_q     <= m_d;
    end
  end

  // Skid payload is only meaningful while s_vld_q is set.
  always_ff @(posedge clk) begin
    s_q <= s_d;
  end

endmodule

// File: tb/tb_mux_pipe_skid.sv
// Bench for mux_pipe_skid: an N=4 and an N=3 (DEFAULT 0xDEADBEEF) instance
// share stimulus and are compared each cycle against a 2-deep FIFO model.
module tb_mux_pipe_skid;

  logic         clk = 1'b0;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic         out_ready;
  logic [1:0]   in_sel;
  logic [127:0] in_data;

  logic         r4, v4, r3, v3;
  logic [31:0]  d4_data, d3_data;
  logic [1:0]   d4_sel, d3_sel;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mux_pipe_skid #(.WIDTH(32), .N(4), .DEFAULT_VAL(32'h0)) u_dut4 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid), .in_ready(r4),
    .out_data(d4_data), .out_sel(d4_sel), .out_valid(v4), .out_ready(out_ready)
  );

  mux_pipe_skid #(.WIDTH(32), .N(3), .DEFAULT_VAL(32'hDEADBEEF)) u_dut3 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data[95:0]), .in_sel(in_sel), .in_valid(in_valid), .in_ready(r3),
    .out_data(d3_data), .out_sel(d3_sel), .out_valid(v3), .out_ready(out_ready)
  );

  // Behavioural model: per instance a FIFO of at most two {sel,data} pairs
  // plus the value currently shown on the output.
  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] data;
  } ent_t;

  ent_t        fifo [2][2];
  int          cnt  [2] = '{0, 0};
  ent_t        disp [2] = '{'0, '0};
  int          nch  [2] = '{4, 3};
  logic [31:0] defv [2] = '{32'h0, 32'hDEADBEEF};

  function automatic logic [31:0] ref_sel(input logic [127:0] d, input logic [1:0] s,
                                          input int n, input logic [31:0] dv);
    if (int'(s) < n) return d[int'(s)*32 +: 32];
    return dv;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        cnt[d]  = 0;
        disp[d] = '0;
      end else if (flush) begin
        cnt[d] = 0;
      end else begin
        logic em, ac;
        em = (cnt[d] > 0) && out_ready;
        ac = in_valid && (cnt[d] < 2);
        if (em) begin
          fifo[d][0] = fifo[d][1];
          cnt[d]     = cnt[d] - 1;
        end
        if (ac) begin
          fifo[d][cnt[d]] = {in_sel, ref_sel(in_data, in_sel, nch[d], defv[d])};
          cnt[d]          = cnt[d] + 1;
        end
        if (cnt[d] > 0) disp[d] = fifo[d][0];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("n4 in_ready",  32'(r4),  32'((cnt[0] < 2) && !rst));
    chk("n4 out_valid", 32'(v4),  32'(cnt[0] > 0));
    chk("n4 out_data",  d4_data,  disp[0].data);
    chk("n4 out_sel",   32'(d4_sel), 32'(disp[0].sel));
    chk("n3 in_ready",  32'(r3),  32'((cnt[1] < 2) && !rst));
    chk("n3 out_valid", 32'(v3),  32'(cnt[1] > 0));
    chk("n3 out_data",  d3_data,  disp[1].data);
    chk("n3 out_sel",   32'(d3_sel), 32'(disp[1].sel));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic ordy);
    in_valid  = v;
    in_sel    = s;
    out_ready = ordy;
  endtask

  initial begin
    int bias;
    rst = 1'b1; flush = 1'b0;
    drive(1'b0, 2'd0, 1'b0);
    in_data = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    tick(); tick();
    chk("reset in_ready",  32'(r4), 32'h0);
    chk("reset out_valid", 32'(v4), 32'h0);
    chk("reset out_data",  d4_data, 32'h0);
    rst = 1'b0;
    tick();
    chk("post-reset in_ready", 32'(r4), 32'h1);

    // Streaming, one transfer per cycle.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), 1'b1);
      tick();
      chk("stream data", d4_data, {4{4'(i + 1), 4'(i + 1)}});
      chk("stream in_ready", 32'(r4), 32'h1);
    end
    drive(1'b0, 2'd0, 1'b1);
    tick();

    // Stall and skid.
    drive(1'b1, 2'd1, 1'b1);
    tick();
    drive(1'b1, 2'd2, 1'b0);
    tick();
    chk("stall hold", d4_data, 32'h22222222);
    chk("stall in_ready", 32'(r4), 32'h0);
    drive(1'b0, 2'd0, 1'b0);
    tick(); tick();
    chk("stall hold2", d4_data, 32'h22222222);
    chk("stall in_ready2", 32'(r4), 32'h0);
    drive(1'b0, 2'd0, 1'b1);
    tick();
    chk("skid drain", d4_data, 32'h33333333);
    chk("skid in_ready", 32'(r4), 32'h1);
    tick();
    chk("drained valid", 32'(v4), 32'h0);
    chk("invalid holds", d4_data, 32'h33333333);

    // Out-of-range select on the N=3 instance.
    drive(1'b1, 2'd3, 1'b1);
    tick();
    chk("oor data", d3_data, 32'hDEADBEEF);
    chk("oor sel", 32'(d3_sel), 32'h3);
    chk("oor valid", 32'(v3), 32'h1);
    chk("n4 sel3", d4_data, 32'h44444444);
    drive(1'b0, 2'd0, 1'b1);
    tick();

    // Flush with both registers full, then with only M full.
    drive(1'b1, 2'd0, 1'b0);
    tick();
    drive(1'b1, 2'd1, 1'b0);
    tick();
    chk("full in_ready", 32'(r4), 32'h0);
    flush = 1'b1; drive(1'b1, 2'd2, 1'b0);
    tick();
    flush = 1'b0; drive(1'b0, 2'd0, 1'b0);
    chk("flush valid", 32'(v4), 32'h0);
    chk("flush in_ready", 32'(r4), 32'h1);
    drive(1'b1, 2'd3, 1'b0);
    tick();
    flush = 1'b1; drive(1'b1, 2'd2, 1'b1);
    tick();
    flush = 1'b0; drive(1'b0, 2'd0, 1'b1);
    chk("flush2 valid", 32'(v4), 32'h0);
    tick();
    chk("flushed input absent", 32'(v4), 32'h0);
    chk("flush keeps data", d4_data, 32'h44444444);

    // Reset while S is full.
    drive(1'b1, 2'd2, 1'b0);
    tick();
    drive(1'b1, 2'd3, 1'b0);
    tick();
    drive(1'b0, 2'd0, 1'b0);
    chk("pre-reset in_ready", 32'(r4), 32'h0);
    rst = 1'b1;
    tick();
    chk("mid reset valid", 32'(v4), 32'h0);
    chk("mid reset data", d4_data, 32'h0);
    chk("mid reset in_ready", 32'(r4), 32'h0);
    rst = 1'b0;
    drive(1'b1, 2'd0, 1'b1);
    #1;
    chk("after reset in_ready", 32'(r4), 32'h1);
    tick();
    chk("after reset data", d4_data, 32'h11111111);
    chk("after reset valid", 32'(v4), 32'h1);
    drive(1'b0, 2'd0, 1'b1);
    tick();

    // Random traffic with varying backpressure, flushes and resets.
    bias = 50;
    for (int i = 0; i < 10000; i++) begin
      if (i % 1000 == 0) bias = (i / 1000 % 3 == 0) ? 90 : ((i / 1000 % 3 == 1) ? 20 : 50);
      in_valid  = ($urandom % 4) != 0;
      in_sel    = 2'($urandom);
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      out_ready = ($urandom % 100) < bias;
      flush     = ($urandom % 64) == 0;
      rst       = ($urandom % 700) == 0;
      tick();
    end
    rst = 1'b0; flush = 1'b0;
    drive(1'b0, 2'd0, 1'b1);
    tick(); tick();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
